mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multicycle signed multiply/divide unit for the MIPS-subset datapath. It is the responder to the control unit's `mult_start`/`div_start` strobes. It accepts the A and B register operands and computes a 64-bit product (radix-2 Booth) or a signed quotient and remainder (restoring division). Results land in `HI_out`/`LO_out`, which feed the HI and LO registers. `done` or `divzero` reports completion back to the control unit.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk` input 1: system clock; every register updates on the rising edge.
- `reset` input 1: asynchronous, active-low; while 0 the unit is held in its reset state.
- `mult_start` input 1: sampled only in IDLE; starts a signed multiply of `A` × `B`.
- `div_start` input 1: sampled only in IDLE; starts a signed divide of `A` ÷ `B`.
- `A` input WIDTH: multiplicand or dividend; latched on the start edge.
- `B` input WIDTH: multiplier or divisor; latched on the start edge.
- `HI_out` output WIDTH: product[63:32] after a multiply, or the remainder after a divide.
- `LO_out` output WIDTH: product[31:0] after a multiply, or the quotient after a divide.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse; `HI_out`/`LO_out` are valid and new in that cycle.
- `divzero` output 1: one-cycle pulse when a divide is requested with `B == 0`.

## Operation
- States:
  - IDLE
  - MULT: 32 Booth iterations.
  - DIV: 32 restoring iterations on magnitudes.
  - FIX: sign correction plus result load.
  - DONE
  - DZ: divide-by-zero report.
- IDLE:
  - `mult_start` = 1 → latch A/B, clear the iteration counter, go to MULT.
  - Otherwise `div_start` = 1 and `B != 0` → latch |A| and |B|, record both operand signs, go to DIV.
  - Otherwise `div_start` = 1 and `B == 0` → go to DZ.
  - Both starts high → multiply wins and `div_start` is ignored.
- Start strobes received outside IDLE are ignored; there is no queuing.
- MULT:
  - Product register is 2·WIDTH+1 bits: {HI, LO=B, q-1=0}.
  - Each cycle: examine {LO[0], q-1}; 01 adds A to HI, 10 subtracts A from HI; then arithmetic-shift the whole register right by 1.
  - After the 32nd iteration, load `HI_out`/`LO_out` and go to DONE.
- DIV:
  - Each cycle: shift {rem, quo} left by 1 and trial-subtract |B|.
  - Non-negative result → keep it and set the new quotient bit to 1; otherwise restore and set the bit to 0.
  - After 32 iterations go to FIX.
- FIX:
  - Quotient is negated when sign(A) XOR sign(B); the remainder takes the sign of A (truncation toward zero, MIPS semantics).
  - Load `LO_out` = quotient and `HI_out` = remainder, then go to DONE.
  - 0x80000000 ÷ −1 → LO = 0x80000000, HI = 0; no flag is raised.
- DONE: `done` = 1 for one cycle, then return to IDLE.
- DZ: `divzero` = 1 for one cycle, then return to IDLE; `HI_out`/`LO_out` are unchanged and `done` is not asserted.
- `HI_out`/`LO_out` hold their last loaded values until the next successful completion.
- Reset values: state IDLE, counter 0, `HI_out` = 0, `LO_out` = 0, `busy` = 0, `done` = 0, `divzero` = 0.
- Reset asserted mid-operation aborts immediately; partial results are discarded and `HI_out`/`LO_out` return to 0.

## Timing
- Edge E0 is the rising edge that samples a start strobe in IDLE.
- Multiply:
  - Iterations occur on edges E1..E32; results are loaded at E32.
  - `done` is high during the cycle after E32, so a sampler sees it at E33. Latency is 33 cycles.
- Divide:
  - Iterations occur on E1..E32 and FIX on E33.
  - `done` is high during the cycle after E33; latency is 34 cycles.
- Divide by zero: `divzero` is high during the cycle after E0; the unit is back in IDLE after E1.
- `busy` rises in the cycle after E0 and falls in the cycle after `done` or `divzero`.
- A new start may be sampled on the edge that leaves DONE or DZ, i.e. the first edge where the state is IDLE.
- All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.

## Structure
- Package `mult_div_pkg` contains:
  - the state encoding: IDLE, MULT, DIV, FIX, DONE, DZ;
  - `ITER_COUNT` = 32;
  - the 6-bit counter width;
  - Booth control-pair constants.
- One natural sub-module, `restoring_div_step`:
  - Purely combinational, one shift/subtract/select step.
  - Instantiated once and reused every DIV cycle.
- The Booth add/subtract and the sign fix stay inline in the top module.

## Test plan
- Multiply 7 × −3 (A=0x00000007, B=0xFFFFFFFD) → `done` at E33, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Multiply 0x80000000 × 0x80000000 → HI=0x40000000, LO=0x00000000; `busy` is high for exactly 33 cycles.
- Divide −7 ÷ 2 → `done` at E34, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide 0x80000000 ÷ −1 → LO=0x80000000, HI=0.
- Divide-by-zero and start handling:
  - Divide 5 ÷ 0 → `divzero` for one cycle after E0, `done` is never asserted, and HI/LO keep their prior values.
  - `mult_start` pulsed mid-operation is ignored.
  - Simultaneous `mult_start` and `div_start` performs a multiply.
- Reset mid-operation: pull `reset` low during cycle 10 of a divide → `busy` = 0 and HI = LO = 0 immediately. After release, multiply 2 × 3 → LO=6, HI=0.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle multiply/divide unit:
// state encoding, iteration count and Booth recoding pairs.
package mult_div_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MULT,
      S_DIV,
      S_FIX,
      S_DONE,
      S_DZ
   } state_e;

   localparam int ITER_COUNT = 32;
   localparam int CNT_W      = 6;

   // {LO[0], q-1} pairs that trigger an add or subtract of A
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mult_div_unit_restoring_div_step.sv
// One restoring-division step on magnitudes: shift {rem, quo}
// left, trial-subtract the divisor, keep or restore.
module restoring_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] dvsr_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // shift in the next dividend bit, subtract, pick result
   always_comb begin
      shifted = {rem_i, quo_i[WIDTH-1]};
      diff    = shifted - {1'b0, dvsr_i};
      if (!diff[WIDTH]) begin
         rem_o = diff[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end else begin
         rem_o = shifted[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide
// (restoring, on magnitudes) feeding the HI/LO registers.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = ITER_COUNT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mult_start,
   input  logic             div_start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] HI_out,
   output logic [WIDTH-1:0] LO_out,
   output logic             busy,
   output logic             done,
   output logic             divzero
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH:0]   prod_q, prod_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   dvsr_q, dvsr_d;
   logic               sa_q, sa_d;
   logic               sb_q, sb_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   logic [WIDTH:0]     hi_ext;
   logic [WIDTH:0]     a_ext;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH:0]   prod_nxt;
   logic [WIDTH-1:0]   step_rem;
   logic [WIDTH-1:0]   step_quo;

   restoring_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i  (rem_q),
      .quo_i  (quo_q),
      .dvsr_i (dvsr_q),
      .rem_o  (step_rem),
      .quo_o  (step_quo)
   );

   // Booth step; the add is one bit wider so the shift-in
   // bit is the true sign even when +/-A overflows WIDTH bits
   always_comb begin
      hi_ext = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
      a_ext  = {mcand_q[WIDTH-1], mcand_q};
      case (prod_q[1:0])
         BOOTH_ADD: sum = hi_ext + a_ext;
         BOOTH_SUB: sum = hi_ext - a_ext;
         default:   sum = hi_ext;
      endcase
      prod_nxt = {sum, prod_q[WIDTH:1]};
   end

   // next-state, datapath and registered output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (mult_start) begin
               mcand_d = A;
               prod_d  = {{WIDTH{1'b0}}, B, 1'b0};
               cnt_d   = '0;
               state_d = S_MULT;
            end else if (div_start) begin
               if (B != '0) begin
                  rem_d   = '0;
                  quo_d   = A[WIDTH-1] ? -A : A;
                  dvsr_d  = B[WIDTH-1] ? -B : B;
                  sa_d    = A[WIDTH-1];
                  sb_d    = B[WIDTH-1];
                  cnt_d   = '0;
                  state_d = S_DIV;
               end else begin
                  state_d = S_DZ;
               end
            end
         end
         S_MULT: begin
            prod_d = prod_nxt;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               hi_d    = prod_nxt[2*WIDTH:WIDTH+1];
               lo_d    = prod_nxt[WIDTH:1];
               state_d = S_DONE;
            end
         end
         S_DIV: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            lo_d    = (sa_q ^ sb_q) ? -quo_q : quo_q;
            hi_d    = sa_q ? -rem_q : rem_q;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         S_DZ:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      dz_d   = (state_d == S_DZ);
   end

   // all state and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign HI_out  = hi_q;
   assign LO_out  = lo_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign divzero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: reference results come
// from plain signed 64-bit arithmetic on the operands.
module tb_mult_div_unit;

   logic        clk;
   logic        reset;
   logic        mult_start;
   logic        div_start;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] HI_out;
   logic [31:0] LO_out;
   logic        busy;
   logic        done;
   logic        divzero;

   mult_div_unit #(
      .WIDTH (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mult_start (mult_start),
      .div_start  (div_start),
      .A          (A),
      .B          (B),
      .HI_out     (HI_out),
      .LO_out     (LO_out),
      .busy       (busy),
      .done       (done),
      .divzero    (divzero)
   );

   typedef struct {
      bit          dz;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
      int          nbusy;
      int          e0;
   } exp_t;

   exp_t        sb[$];
   int          total;
   int          bad;
   int          cyc;
   int          completed;
   logic [31:0] last_hi;
   logic [31:0] last_lo;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input bit m, input bit d,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t   e;
      longint sa;
      longint sbv;
      longint r64;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      e.e0 = 0;
      if (m) begin
         r64     = sa * sbv;
         e.dz    = 1'b0;
         e.hi    = r64[63:32];
         e.lo    = r64[31:0];
         e.lat   = 33;
         e.nbusy = 33;
      end else if (d && b == 32'h0) begin
         e.dz    = 1'b1;
         e.hi    = last_hi;
         e.lo    = last_lo;
         e.lat   = 1;
         e.nbusy = 1;
      end else begin
         r64     = sa / sbv;
         e.lo    = r64[31:0];
         r64     = sa % sbv;
         e.hi    = r64[31:0];
         e.dz    = 1'b0;
         e.lat   = 34;
         e.nbusy = 34;
      end
      return e;
   endfunction

   task automatic monitor();
      exp_t e;
      int   lat;
      forever begin
         @(negedge clk);
         if (reset && (done || divzero)) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_out done=%0b dz=%0b hi=%h lo=%h",
                        done, divzero, HI_out, LO_out);
            end else begin
               e   = sb.pop_front();
               lat = cyc - e.e0 + 1;
               if (divzero !== e.dz || done !== !e.dz ||
                   HI_out !== e.hi || LO_out !== e.lo ||
                   lat != e.lat) begin
                  bad++;
                  $display("FAIL result got dz=%0b done=%0b hi=%h lo=%h lat=%0d want dz=%0b hi=%h lo=%h lat=%0d",
                           divzero, done, HI_out, LO_out, lat,
                           e.dz, e.hi, e.lo, e.lat);
               end
            end
            completed++;
         end
      end
   endtask

   task automatic issue(input bit m, input bit d,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int pulse_at);
      exp_t e;
      int   nb;
      int   c0;
      bit   ok;
      e = model(m, d, a, b);
      @(negedge clk);
      mult_start = m;
      div_start  = d;
      A = a;
      B = b;
      @(posedge clk);
      #1;
      e.e0 = cyc;
      sb.push_back(e);
      c0 = completed;
      if (!e.dz) begin
         last_hi = e.hi;
         last_lo = e.lo;
      end
      @(negedge clk);
      mult_start = 1'b0;
      div_start  = 1'b0;
      A = $urandom;
      B = $urandom;
      nb = 0;
      ok = 1'b0;
      for (int i = 1; i <= 80 && !ok; i++) begin
         if (i > 1) begin
            @(negedge clk);
            mult_start = (i == pulse_at);
         end
         if (busy) nb++;
         if (completed != c0 && !busy) ok = 1'b1;
      end
      mult_start = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL timeout a=%h b=%h busy=%0b want completion",
                  a, b, busy);
      end else if (nb != e.nbusy) begin
         bad++;
         $display("FAIL busy_cycles got %0d want %0d", nb, e.nbusy);
      end
   endtask

   function automatic logic [31:0] pick();
      int          s;
      logic [31:0] v;
      s = $urandom_range(0, 5);
      case (s)
         0:       v = 32'h8000_0000;
         1:       v = 32'hFFFF_FFFF;
         2:       v = $urandom_range(0, 20);
         3:       v = -$urandom_range(1, 20);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got %h want %h", nm, got, want);
      end
   endtask

   initial begin
      int k;
      total      = 0;
      bad        = 0;
      completed  = 0;
      last_hi    = '0;
      last_lo    = '0;
      reset      = 1'b0;
      mult_start = 1'b0;
      div_start  = 1'b0;
      A          = '0;
      B          = '0;
      fork
         monitor();
      join_none
      repeat (3) @(negedge clk);
      chk("rst_hi", HI_out, 32'h0);
      chk("rst_lo", LO_out, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_dz", {31'h0, divzero}, 32'h0);
      reset = 1'b1;
      @(negedge clk);

      issue(1, 0, 32'h0000_0007, 32'hFFFF_FFFD, 0);
      issue(1, 0, 32'h8000_0000, 32'h8000_0000, 0);
      issue(0, 1, 32'hFFFF_FFF9, 32'h0000_0002, 0);
      issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      issue(1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 0);
      issue(0, 1, 32'h0000_0005, 32'h0000_0000, 0);
      issue(0, 1, 32'h0000_0064, 32'h0000_0007, 5);
      repeat (40) @(negedge clk);
      chk("idle_after_pulse", {31'h0, busy}, 32'h0);
      issue(1, 1, 32'hFFFF_FFF6, 32'h0000_0003, 0);

      repeat (40) begin
         k = $urandom_range(0, 9);
         if (k < 4)
            issue(1, 0, pick(), pick(), 0);
         else if (k < 8)
            issue(0, 1, pick(), pick(), 0);
         else if (k == 8)
            issue(0, 1, pick(), 32'h0, 0);
         else
            issue(1, 1, pick(), pick(), 0);
      end

      @(negedge clk);
      div_start = 1'b1;
      A = 32'h0001_0000;
      B = 32'h0000_0003;
      @(negedge clk);
      div_start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_hi", HI_out, 32'h0);
      chk("abort_lo", LO_out, 32'h0);
      sb.delete();
      last_hi = '0;
      last_lo = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      issue(1, 0, 32'h0000_0002, 32'h0000_0003, 0);
      chk("post_rst_lo", LO_out, 32'h6);
      chk("post_rst_hi", HI_out, 32'h0);

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL pending got %0d want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
